// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// Carries op/operands/flush in, and start/busy/read data back out.
interface muldiv_unit_if;
    logic        req;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] MDU_out;

    modport master (
        output req, MDUOp, A, B,
        input  start, busy, MDU_out
    );

    modport slave (
        input  req, MDUOp, A, B,
        output start, busy, MDU_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Ports: clk, reset (sync, active-high), bus (slave: req/MDUOp/A/B in; start/busy/MDU_out out).
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;

    logic is_md;
    logic is_mul;

    assign is_md  = (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);
    assign is_mul = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);

    assign bus.busy  = (state_q == S_BUSY);
    assign bus.start = is_md && !bus.req && (state_q == S_IDLE);

    // Result is computed from the latched operands; it only matters
    // on the completing edge, so no iteration is needed.
    logic        sgn_mul, sgn_div, is_div_q;
    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

    always_comb begin
        sgn_mul  = (op_q == OP_MULT);
        sgn_div  = (op_q == OP_DIV);
        is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
        // Sign- or zero-extend to 64 bits; low 64 bits of the product
        // are then correct for both signednesses.
        mul_a = {{32{sgn_mul & a_q[31]}}, a_q};
        mul_b = {{32{sgn_mul & b_q[31]}}, b_q};
        prod  = mul_a * mul_b;
        // Signed divide via magnitudes avoids the INT_MIN / -1 trap:
        // |0x80000000| fits in 32 unsigned bits and the signs cancel.
        a_neg   = sgn_div & a_q[31];
        b_neg   = sgn_div & b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.MDUOp;
                    state_d = S_BUSY;
                    cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end else if (!bus.req && bus.MDUOp == OP_MTHI) begin
                    hi_d = bus.A;
                end else if (!bus.req && bus.MDUOp == OP_MTLO) begin
                    lo_d = bus.A;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!is_div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        bus.MDU_out = 32'd0;
        if (bus.MDUOp == OP_MFHI)
            bus.MDU_out = hi_q;
        else if (bus.MDUOp == OP_MFLO)
            bus.MDU_out = lo_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    muldiv_unit_if mif();

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, input logic exp_start, input string tag);
        @(negedge clk);
        mif.MDUOp = op;
        mif.A     = a;
        mif.B     = b;
        mif.req   = rq;
        #1 chk(tag, {31'd0, mif.start}, {31'd0, exp_start});
    endtask

    // Counts busy cycles; leaves us at the first falling edge with busy low.
    task automatic wait_busy(input int exp_n, input string tag);
        int n;
        @(negedge clk);
        mif.MDUOp = 4'd0;
        mif.req   = 1'b0;
        n = 0;
        while (mif.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, exp_n);
    endtask

    task automatic rd(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        mif.req   = 1'b0;
        mif.MDUOp = 4'd5;
        #1 chk({tag, "_hi"}, mif.MDU_out, exp_hi);
        mif.MDUOp = 4'd6;
        #1 chk({tag, "_lo"}, mif.MDU_out, exp_lo);
        mif.MDUOp = 4'd0;
        #1 chk({tag, "_none"}, mif.MDU_out, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        mif.req   = 1'b0;
        mif.MDUOp = 4'd0;
        mif.A     = '0;
        mif.B     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        rd(32'd0, 32'd0, "rst");

        // 1: MULT -2 * 3
        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, "mult_start");
        wait_busy(5, "mult_busy");
        rd(32'hFFFFFFFF, 32'hFFFFFFFA, "mult");

        // 2: MULTU max * max
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, "multu_start");
        wait_busy(5, "multu_busy");
        rd(32'hFFFFFFFE, 32'h00000001, "multu");

        // 3: DIV -7 / 2, DIVU 7 / 2
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, "div_start");
        wait_busy(10, "div_busy");
        rd(32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        issue(4'd4, 32'd7, 32'd2, 1'b0, 1'b1, "divu_start");
        wait_busy(10, "divu_busy");
        rd(32'd1, 32'd3, "divu");

        // 4: overflow divide, then divide by zero
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, "ovf_start");
        wait_busy(10, "ovf_busy");
        rd(32'd0, 32'h80000000, "ovf");
        issue(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0, "mthi_start");
        issue(4'd8, 32'h5678, 32'd0, 1'b0, 1'b0, "mtlo_start");
        issue(4'd3, 32'd5, 32'd0, 1'b0, 1'b1, "dz_start");
        wait_busy(10, "dz_busy");
        rd(32'h1234, 32'h5678, "dz");

        // 5: flush suppresses issue and moves
        issue(4'd1, 32'd2, 32'd3, 1'b1, 1'b0, "req_start");
        @(negedge clk);
        mif.MDUOp = 4'd0;
        mif.req   = 1'b0;
        chk("req_busy", {31'd0, mif.busy}, 32'd0);
        rd(32'h1234, 32'h5678, "req_mult");
        issue(4'd8, 32'h9999, 32'd0, 1'b1, 1'b0, "req_mtlo");
        @(negedge clk);
        rd(32'h1234, 32'h5678, "req_mtlo");
        issue(4'd9, 32'd1, 32'd1, 1'b0, 1'b0, "op9_start");
        issue(4'd8, 32'h42, 32'd0, 1'b0, 1'b0, "mtlo2");
        @(negedge clk);
        mif.MDUOp = 4'd0;
        rd(32'h1234, 32'h42, "mtlo2");

        // 6a: MTHI while busy is ignored
        issue(4'd1, 32'd2, 32'd3, 1'b0, 1'b1, "mb_start");
        issue(4'd7, 32'hDEAD, 32'd0, 1'b0, 1'b0, "mb_mthi");
        wait_busy(4, "mb_busy");
        rd(32'd0, 32'd6, "mb");

        // 6b: reset on the 4th busy cycle of a DIV
        issue(4'd7, 32'hAAAA, 32'd0, 1'b0, 1'b0, "pre_mthi");
        issue(4'd4, 32'd100, 32'd7, 1'b0, 1'b1, "rs_start");
        @(negedge clk);
        mif.MDUOp = 4'd0;
        repeat (3) @(negedge clk);
        chk("rs_busy4", {31'd0, mif.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_busy", {31'd0, mif.busy}, 32'd0);
        rd(32'd0, 32'd0, "rs");
        repeat (12) @(negedge clk);
        chk("rs_late_busy", {31'd0, mif.busy}, 32'd0);
        rd(32'd0, 32'd0, "rs_late");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit; owns the HI/LO registers.
- Produces the start/busy pair consumed by the hazard stall unit, which holds the decode stage while a mult/div-class instruction waits.
- Accepts the E-stage operation plus forwarded rs/rt values.
- Results are read back through MFHI/MFLO in E.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU start (must be >= 1).
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  exception/interrupt flush this cycle; suppresses any E-stage issue.
- MDUOp  input  4  operation code:
  - 0 = none, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU
  - 5 = MFHI, 6 = MFLO, 7 = MTHI, 8 = MTLO
  - 9–15 = none
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- start  output  1  combinational; high in the cycle a mult/div starts.
- busy  output  1  registered; high while an operation is in flight.
- MDU_out  output  32  combinational read data: HI for MFHI, LO for MFLO, 0 otherwise.

Behaviour:
- Reset (synchronous): HI=0, LO=0, busy=0, cycle counter=0, latched operands/op=0. MDU_out follows HI/LO, so it reads 0 after reset.
- start = (MDUOp in 1..4) && !req && !busy. Purely combinational, so the stall unit sees it in the same cycle.
- On an edge with start=1:
  - latch A, B and op;
  - busy<=1;
  - counter<=MULT_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4).
- While busy, each edge decrements the counter.
- On the edge where the counter equals 1: busy<=0, counter<=0, and HI/LO take the result on that same edge.
  - Net effect: busy is high for exactly N cycles following the start cycle.
  - An MFHI/MFLO in the cycle after busy falls reads the new value.
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero (B==0 at start, ops 3/4): still goes busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO (ops 7/8): on an edge with !req && !busy, HI<=A (resp. LO<=A). Ignored while busy or when req=1.
- MFHI/MFLO never alter state. While busy, MDU_out returns the stale HI/LO; the stall unit prevents this case from arising.
- Any op presented while busy is ignored and does not restart the counter (defensive; the stall unit normally blocks it).
- req=1 does not abort an operation already in flight: an instruction that started before the exception has retired and must complete.
- Reset asserted mid-operation: all state is cleared on that edge, busy=0 next cycle, and no HI/LO write occurs.
- The result may be produced iteratively or computed at start and delayed. Observable timing must be exactly as above.

Test Plan:
1. Reset, then MULT with A=0xFFFFFFFE (-2), B=3 → start=1 for one cycle; busy high for exactly 5 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
2. MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
3. DIV with A=-7 (0xFFFFFFF9), B=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 → LO=3, HI=1.
4. DIV with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. DIV with B=0 after MTHI 0x1234 / MTLO 0x5678 → busy for 10 cycles; HI/LO remain 0x1234/0x5678.
5. MULT presented with req=1 → start=0, busy stays 0, HI/LO unchanged. MTLO with req=1 → LO unchanged.
6. Start DIV, assert reset on the 4th busy cycle → busy=0, HI=LO=0 on the next cycle; no later write. Separately, an MTHI presented mid-busy is ignored.
